// File: rtl/game_pkg.sv
// Shared constants for the score path: FSM state encoding, default timings,
// and the saturating event-tally helper.
package game_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] DISABLED     = 2'd0;
  localparam logic [STATE_W-1:0] ARMED        = 2'd1;
  localparam logic [STATE_W-1:0] LOCKOUT      = 2'd2;
  localparam logic [STATE_W-1:0] WAIT_RELEASE = 2'd3;

  // 10 ms debounce and 50 ms lockout at a 50 MHz clock
  localparam int unsigned DEBOUNCE_10MS = 500000;
  localparam int unsigned LOCKOUT_50MS  = 2500000;

  localparam int unsigned EVT_W = 8;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (v == {EVT_W{1'b1}}) ? v : v + EVT_W'(1);
  endfunction

endpackage

// File: rtl/score_pulse_gen_if.sv
// Hit input / score output bundle between the button front end and the counter.
interface score_pulse_gen_if;
  import game_pkg::*;

  logic             hit_raw;
  logic             game_en;
  logic             score_update;
  logic             score_en;
  logic             armed;
  logic [EVT_W-1:0] event_total;

  modport master (
    output hit_raw, game_en,
    input  score_update, score_en, armed, event_total
  );

  modport slave (
    input  hit_raw, game_en,
    output score_update, score_en, armed, event_total
  );
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus stable-interval debounce for one button level.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             btn_sync;
  logic [CNT_W-1:0] db_cnt;

  // Bring the asynchronous level into the clock domain
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1       <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      s1       <= btn_raw;
      btn_sync <= s1;
    end
  end

  // Flip the clean level only after the synced level differs for the full interval
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_sync == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/score_pulse_gen.sv
// Converts a debounced hit into one clean score pulse per press, with a
// post-pulse lockout, game-enable gating and a saturating pulse tally.
module score_pulse_gen
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_50MS,
  parameter int unsigned CNT_W           = 22
) (
  input logic               clk,
  input logic               rst,
  score_pulse_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  logic               hit_db;
  logic               hit_db_q;
  logic               rise;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [CNT_W-1:0]   lock_cnt;
  logic [CNT_W-1:0]   lock_nxt;
  logic               pulse_nxt;
  logic [EVT_W-1:0]   total_nxt;
  logic               score_update_q;
  logic               score_en_q;
  logic               armed_q;
  logic [EVT_W-1:0]   event_total_q;

  input_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_hit_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.hit_raw),
    .btn_db  (hit_db)
  );

  assign rise = hit_db & ~hit_db_q;

  // Next state, lockout count, pulse request and tally update
  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_cnt;
    pulse_nxt = 1'b0;
    total_nxt = event_total_q;
    if (!bus.game_en) begin
      state_nxt = DISABLED;
      lock_nxt  = '0;
    end else begin
      case (state)
        DISABLED: begin
          // a button already held at game start must be released first
          state_nxt = hit_db ? WAIT_RELEASE : ARMED;
        end
        ARMED: begin
          if (rise) begin
            pulse_nxt = 1'b1;
            state_nxt = LOCKOUT;
            lock_nxt  = '0;
            total_nxt = sat_inc(event_total_q);
          end
        end
        LOCKOUT: begin
          if (lock_cnt == LOCK_LAST) begin
            state_nxt = WAIT_RELEASE;
            lock_nxt  = '0;
          end else begin
            lock_nxt = lock_cnt + CNT_W'(1);
          end
        end
        WAIT_RELEASE: begin
          if (!hit_db) state_nxt = ARMED;
        end
        default: state_nxt = DISABLED;
      endcase
    end
  end

  // State and registered outputs; status flags lag the state by one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= DISABLED;
      lock_cnt       <= '0;
      hit_db_q       <= 1'b0;
      score_update_q <= 1'b0;
      score_en_q     <= 1'b0;
      armed_q        <= 1'b0;
      event_total_q  <= '0;
    end else begin
      state          <= state_nxt;
      lock_cnt       <= lock_nxt;
      hit_db_q       <= hit_db;
      score_update_q <= pulse_nxt;
      score_en_q     <= (state != DISABLED);
      armed_q        <= (state == ARMED);
      event_total_q  <= total_nxt;
    end
  end

  assign bus.score_update = score_update_q;
  assign bus.score_en     = score_en_q;
  assign bus.armed        = armed_q;
  assign bus.event_total  = event_total_q;

endmodule

// File: tb/tb_score_pulse_gen.sv
// Self-checking bench for score_pulse_gen: reset/clean-hit vector table,
// hand-written corner sequences and randomized traffic against a reference model.
module tb_score_pulse_gen;
  import game_pkg::*;

  localparam int unsigned DB = 4;
  localparam int unsigned LK = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_pulse_gen_if bus ();

  score_pulse_gen #(
    .DEBOUNCE_CYCLES (DB),
    .LOCKOUT_CYCLES  (LK),
    .CNT_W           (22)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: what the game should see, derived from the behavioural rules
  typedef enum {M_OFF, M_READY, M_HOLDOFF, M_RELEASE} mode_t;
  mode_t mode;
  bit    hist[$];        // raw samples taken at previous edges (newest last)
  bit    m_db, m_db_prev;
  int    diff_run;       // consecutive edges the synced level disagreed with m_db
  int    cyc, pulse_cyc;
  bit    m_pulse, m_en, m_armed;
  int    m_total;

  function automatic void model_edge(input bit r, input bit raw, input bit en);
    bit sync_old;
    bit rise;
    if (!r) begin
      hist.delete();
      m_db = 0; m_db_prev = 0; diff_run = 0;
      mode = M_OFF; cyc = 0; pulse_cyc = 0;
      m_pulse = 0; m_en = 0; m_armed = 0; m_total = 0;
      return;
    end
    // synced level = raw as sampled two edges before this one
    sync_old = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    rise     = m_db && !m_db_prev;
    m_en     = (mode != M_OFF);
    m_armed  = (mode == M_READY);
    m_pulse  = en && (mode == M_READY) && rise;
    if (m_pulse && m_total < 255) m_total = m_total + 1;
    if (!en) mode = M_OFF;
    else begin
      case (mode)
        M_OFF:     mode = m_db ? M_RELEASE : M_READY;
        M_READY:   if (rise) begin mode = M_HOLDOFF; pulse_cyc = cyc; end
        M_HOLDOFF: if (cyc - pulse_cyc == int'(LK)) mode = M_RELEASE;
        M_RELEASE: if (!m_db) mode = M_READY;
      endcase
    end
    m_db_prev = m_db;
    if (sync_old != m_db) begin
      diff_run = diff_run + 1;
      if (diff_run == int'(DB)) begin m_db = sync_old; diff_run = 0; end
    end else begin
      diff_run = 0;
    end
    hist.push_back(raw);
    if (hist.size() > 2) void'(hist.pop_front());
    cyc = cyc + 1;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: actual %0d required %0d", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model, compare every output just after the edge
  task automatic step(input bit r, input bit raw, input bit en);
    rst         = r;
    bus.hit_raw = raw;
    bus.game_en = en;
    @(posedge clk);
    model_edge(r, raw, en);
    #1;
    chk("model_score_update", 8'(bus.score_update), 8'(m_pulse));
    chk("model_score_en",     8'(bus.score_en),     8'(m_en));
    chk("model_armed",        8'(bus.armed),        8'(m_armed));
    chk("model_event_total",  bus.event_total,      8'(m_total));
    if (bus.score_update === 1'b1) pulses++;
  endtask

  task automatic run(input bit raw, input bit en, input int n);
    for (int i = 0; i < n; i++) step(1'b1, raw, en);
  endtask

  typedef struct {
    bit       r, raw, en;
    bit       pulse, sen, arm;
    bit [7:0] tot;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // reset with button held, release, then one clean press
    for (int i = 0; i < 3; i++)   vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    for (int i = 6; i < 12; i++)  vecs[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
    for (int i = 13; i < 20; i++) vecs[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].r, vecs[i].raw, vecs[i].en);
      chk($sformatf("tbl%0d_score_update", i), 8'(bus.score_update), 8'(vecs[i].pulse));
      chk($sformatf("tbl%0d_score_en", i),     8'(bus.score_en),     8'(vecs[i].sen));
      chk($sformatf("tbl%0d_armed", i),        8'(bus.armed),        8'(vecs[i].arm));
      chk($sformatf("tbl%0d_event_total", i),  bus.event_total,      vecs[i].tot);
    end

    // held through lockout: no second pulse
    pulses = 0;
    run(1'b1, 1'b1, 30);
    chk("held_no_repulse", 8'(pulses), 8'd0);
    run(1'b0, 1'b1, 12);
    chk("rearmed_after_release", 8'(bus.armed), 8'd1);
    pulses = 0;
    run(1'b1, 1'b1, 6);
    chk("press2_no_early_pulse", 8'(pulses), 8'd0);
    run(1'b1, 1'b1, 1);
    chk("press2_pulse_at_7", 8'(pulses), 8'd1);
    chk("press2_total", bus.event_total, 8'd2);
    run(1'b1, 1'b1, 10);

    // bounce: short toggles never qualify, then stable hold pulses once
    run(1'b0, 1'b1, 14);
    pulses = 0;
    for (int k = 0; k < 2; k++) begin
      run(1'b1, 1'b1, 2);
      run(1'b0, 1'b1, 2);
    end
    chk("bounce_no_pulse", 8'(pulses), 8'd0);
    run(1'b1, 1'b1, 6);
    chk("bounce_hold_no_early", 8'(pulses), 8'd0);
    run(1'b1, 1'b1, 1);
    chk("bounce_hold_pulse", 8'(pulses), 8'd1);
    chk("bounce_total", bus.event_total, 8'd3);

    // disable mid-lockout, re-enable with button still held
    run(1'b1, 1'b1, 1);
    pulses = 0;
    run(1'b1, 1'b0, 2);
    chk("disabled_score_en", 8'(bus.score_en), 8'd0);
    run(1'b1, 1'b0, 20);
    run(1'b1, 1'b1, 20);
    chk("reenable_held_no_pulse", 8'(pulses), 8'd0);
    chk("reenable_held_not_armed", 8'(bus.armed), 8'd0);
    run(1'b0, 1'b1, 12);
    run(1'b1, 1'b1, 10);
    chk("reenable_press_pulse", 8'(pulses), 8'd1);
    chk("reenable_total", bus.event_total, 8'd4);

    // saturation: every hit still pulses, tally sticks at 255
    pulses = 0;
    for (int h = 0; h < 260; h++) begin
      run(1'b0, 1'b1, 12);
      run(1'b1, 1'b1, 20);
    end
    chk("sat_pulse_count", 8'(pulses / 2), 8'd130);
    chk("sat_total", bus.event_total, 8'd255);

    // randomized traffic against the model
    for (int seg = 0; seg < 400; seg++) begin
      bit raw_v, en_v;
      int len;
      raw_v = 1'($urandom % 2);
      en_v  = (($urandom % 8) != 0);
      len   = int'($urandom_range(1, 12));
      if (($urandom % 50) == 0) begin
        step(1'b0, raw_v, en_v);
      end else begin
        run(raw_v, en_v, len);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_pulse_gen.md
Name: score_pulse_gen

Overview:
Upstream stage of the score counter. Turns a raw, bouncy hit/button input into clean single-cycle score_update pulses, and supplies the counter's EN. Each physical hit produces exactly one pulse. The output is registered and glitch-free, so the counter can safely use it as its clock/event edge. It also gates scoring with the game-active state and keeps a debug tally of issued pulses.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles hit_sync must differ stably from hit_db before hit_db flips (10 ms @ 50 MHz); must be >= 2.
LOCKOUT_CYCLES, 2500000, minimum cycles after a pulse before re-arming is possible; must be >= 1.
CNT_W, 22, width of the debounce and lockout counters; must hold max(DEBOUNCE_CYCLES, LOCKOUT_CYCLES).

Ports:
clk  input  1  system clock; all logic on posedge clk
rst  input  1  synchronous, active-low reset (rst==0 at posedge clk resets)
hit_raw  input  1  asynchronous raw hit/button level, active-high
game_en  input  1  game active; scoring allowed only while high
score_update  output  1  one-cycle high pulse per accepted hit; drives counter Score_update
score_en  output  1  registered copy of (state != DISABLED); drives counter EN
armed  output  1  high while state == ARMED
event_total  output  8  saturating count of score_update pulses since reset

Behaviour:
- Reset (rst==0 at posedge clk): sync FFs=0, hit_db=0, hit_db_q=0, db_cnt=0, lock_cnt=0, state=DISABLED, score_update=0, score_en=0, armed=0, event_total=0. Reset overrides all else, including mid-lockout or mid-debounce.
- Synchroniser: two-flop chain hit_raw -> s1 -> hit_sync.
- Debounce:
  - hit_sync==hit_db: db_cnt <= 0.
  - Otherwise db_cnt increments. When db_cnt==DEBOUNCE_CYCLES-1: hit_db <= hit_sync, db_cnt <= 0.
  - A stable raw change reaches hit_db DEBOUNCE_CYCLES+2 cycles later. Any bounce back restarts the count.
  - hit_db_q is hit_db delayed one cycle. rise = hit_db & ~hit_db_q.
- FSM states: DISABLED, ARMED, LOCKOUT, WAIT_RELEASE.
  - DISABLED: when game_en==1, go to WAIT_RELEASE if hit_db==1, else ARMED. A button already held at game start never scores.
  - ARMED: on rise, set score_update<=1 for exactly one cycle, go to LOCKOUT, clear lock_cnt, and increment event_total (saturating at 255).
  - LOCKOUT: lock_cnt increments. At lock_cnt==LOCKOUT_CYCLES-1, go to WAIT_RELEASE. Rises during lockout are ignored, not queued.
  - WAIT_RELEASE: when hit_db==0, go to ARMED. Next pulse needs a fresh rise.
  - game_en==0 in any state: next state DISABLED, no pulse issued that cycle; lock_cnt cleared.
- score_update:
  - Registered, high exactly one cycle, 0 in every other cycle.
  - Minimum spacing between pulses is LOCKOUT_CYCLES+1 cycles.
  - Latency: rise seen in ARMED at cycle t gives score_update high at t+1.
- score_en and armed are registered and update one cycle after the state change.
- Debounce logic runs in all states, including DISABLED.

Decomposition:
- Shared package (game_pkg): state encoding constants (DISABLED=2'd0, ARMED=2'd1, LOCKOUT=2'd2, WAIT_RELEASE=2'd3) and default timing constants DEBOUNCE_10MS, LOCKOUT_50MS.
- One sub-module: input_debouncer. It contains the synchroniser and debounce counter, is parameterised by DEBOUNCE_CYCLES and CNT_W, and outputs hit_db. It is reusable for the other console buttons.

Test Plan (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8):
- Reset: hold rst=0 for 3 cycles with hit_raw=1, game_en=1 -> all outputs 0. Release rst with hit_raw=0 -> ARMED and score_en=1 two cycles later.
- Clean hit: in ARMED, raise hit_raw and hold for 20 cycles -> exactly one score_update pulse, 7 cycles after the raw edge; event_total=1; armed=0.
- Bounce: toggle hit_raw 1,0,1,0 every 2 cycles, then hold 1 -> no pulse during toggling, one pulse after a stable 4+2 cycles.
- Held through lockout: keep hit_raw=1 for 40 cycles -> a single pulse only. Release, wait 7 cycles, press again -> second pulse; event_total=2.
- Disable mid-lockout: game_en=0 two cycles after a pulse -> score_en=0 next cycle, no further pulses. Re-enable with the button held -> WAIT_RELEASE, no pulse until release and re-press.
- Saturation: issue 260 qualified hits -> event_total stays at 255, and score_update still pulses for every hit.
